// File: rtl/eth_helper_pkg.sv
// Shared definitions for the AR-to-stream bridge: stream FSM states and the
// metadata word field layout (tail fields sit directly above address and ID).
package eth_helper_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } stream_state_t;

    localparam int AR_LEN_W   = 8;
    localparam int AR_SIZE_W  = 3;
    localparam int AR_BURST_W = 2;
    localparam int AR_PROT_W  = 3;
    localparam int AR_CACHE_W = 4;

    // Offsets relative to ADDR_WIDTH+ID_WIDTH; with 64/32 this gives len at 96.
    localparam int PKT_LEN_OFS   = 0;
    localparam int PKT_SIZE_OFS  = PKT_LEN_OFS + AR_LEN_W;
    localparam int PKT_BURST_OFS = PKT_SIZE_OFS + AR_SIZE_W;
    localparam int PKT_PROT_OFS  = PKT_BURST_OFS + AR_BURST_W;
    localparam int PKT_CACHE_OFS = PKT_PROT_OFS + AR_PROT_W;
    localparam int PKT_TAIL_W    = PKT_CACHE_OFS + AR_CACHE_W;

endpackage

// File: rtl/axi_ar_to_stream_meta_fifo.sv
// Synchronous FIFO holding AR metadata words; pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate counter.
module meta_fifo #(
    parameter int WIDTH = 116,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("meta_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    // A pop frees the head slot this edge, so a push into a full FIFO is legal then.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_rdata = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/axi_ar_to_stream.sv
// Forwards AXI AR beats through a one-entry holding slot and publishes a
// metadata word per accepted beat on a one-cycle-per-packet stream port.
module axi_ar_to_stream
    import eth_helper_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  ready,
    output logic                  valid,
    output logic                  in_progress,
    output logic [DATA_WIDTH-1:0] data,
    input  logic [ID_WIDTH-1:0]   AXIS_arid,
    input  logic [ADDR_WIDTH-1:0] AXIS_araddr,
    input  logic [AR_LEN_W-1:0]   AXIS_arlen,
    input  logic [AR_SIZE_W-1:0]  AXIS_arsize,
    input  logic [AR_BURST_W-1:0] AXIS_arburst,
    input  logic [AR_PROT_W-1:0]  AXIS_arprot,
    input  logic [AR_CACHE_W-1:0] AXIS_arcache,
    input  logic                  AXIS_arvalid,
    output logic                  AXIS_arready,
    output logic [ID_WIDTH-1:0]   AXIM_arid,
    output logic [ADDR_WIDTH-1:0] AXIM_araddr,
    output logic [AR_LEN_W-1:0]   AXIM_arlen,
    output logic [AR_SIZE_W-1:0]  AXIM_arsize,
    output logic [AR_BURST_W-1:0] AXIM_arburst,
    output logic [AR_PROT_W-1:0]  AXIM_arprot,
    output logic [AR_CACHE_W-1:0] AXIM_arcache,
    output logic                  AXIM_arvalid,
    input  logic                  AXIM_arready
);

    localparam int META_W   = ADDR_WIDTH + ID_WIDTH + PKT_TAIL_W;
    localparam int TAIL_LSB = ADDR_WIDTH + ID_WIDTH;

    if (DATA_WIDTH < META_W) begin : g_width_check
        $error("axi_ar_to_stream: DATA_WIDTH too small for the metadata word");
    end

    logic                  r_rst_done;
    logic                  r_hold_valid;
    logic [ID_WIDTH-1:0]   r_arid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [AR_LEN_W-1:0]   r_arlen;
    logic [AR_SIZE_W-1:0]  r_arsize;
    logic [AR_BURST_W-1:0] r_arburst;
    logic [AR_PROT_W-1:0]  r_arprot;
    logic [AR_CACHE_W-1:0] r_arcache;
    logic [DATA_WIDTH-1:0] r_data;
    stream_state_t         r_state;
    stream_state_t         w_state_next;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [META_W-1:0]     w_meta;
    logic [META_W-1:0]     w_head;

    // r_rst_done keeps arready low while reset is held and rises one edge after release.
    assign AXIS_arready = r_rst_done && (!r_hold_valid || AXIM_arready) && !w_fifo_full;
    assign w_push       = AXIS_arvalid && AXIS_arready;

    always_comb begin
        w_meta = '0;
        w_meta[0 +: ADDR_WIDTH]                    = AXIS_araddr;
        w_meta[ADDR_WIDTH +: ID_WIDTH]             = AXIS_arid;
        w_meta[TAIL_LSB + PKT_LEN_OFS +: AR_LEN_W]     = AXIS_arlen;
        w_meta[TAIL_LSB + PKT_SIZE_OFS +: AR_SIZE_W]   = AXIS_arsize;
        w_meta[TAIL_LSB + PKT_BURST_OFS +: AR_BURST_W] = AXIS_arburst;
        w_meta[TAIL_LSB + PKT_PROT_OFS +: AR_PROT_W]   = AXIS_arprot;
        w_meta[TAIL_LSB + PKT_CACHE_OFS +: AR_CACHE_W] = AXIS_arcache;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rst_done   <= 1'b0;
            r_hold_valid <= 1'b0;
            r_arid       <= '0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arsize     <= '0;
            r_arburst    <= '0;
            r_arprot     <= '0;
            r_arcache    <= '0;
        end else begin
            r_rst_done <= 1'b1;
            // Payload only loads on an upstream accept, which cannot happen while stalled.
            if (w_push) begin
                r_hold_valid <= 1'b1;
                r_arid       <= AXIS_arid;
                r_araddr     <= AXIS_araddr;
                r_arlen      <= AXIS_arlen;
                r_arsize     <= AXIS_arsize;
                r_arburst    <= AXIS_arburst;
                r_arprot     <= AXIS_arprot;
                r_arcache    <= AXIS_arcache;
            end else if (AXIM_arready) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    assign AXIM_arvalid = r_hold_valid;
    assign AXIM_arid    = r_arid;
    assign AXIM_araddr  = r_araddr;
    assign AXIM_arlen   = r_arlen;
    assign AXIM_arsize  = r_arsize;
    assign AXIM_arburst = r_arburst;
    assign AXIM_arprot  = r_arprot;
    assign AXIM_arcache = r_arcache;

    meta_fifo #(
        .WIDTH (META_W),
        .DEPTH (FIFO_DEPTH)
    ) u_meta_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_wdata (w_meta),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) r_data <= DATA_WIDTH'(w_head);
        end
    end

    always_comb begin
        w_state_next = r_state;
        valid        = 1'b0;
        in_progress  = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                valid = !w_fifo_empty;
                w_pop = ready && !w_fifo_empty;
                if (w_pop) w_state_next = ST_SEND;
            end
            ST_SEND: begin
                in_progress  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign data = r_data;

endmodule

// File: tb/tb_axi_ar_to_stream.sv
// Bench for axi_ar_to_stream: directed vector table, multi-cycle corner
// sequences and randomized traffic against a queue-based reference model.
module tb_axi_ar_to_stream;

    localparam int DW    = 128;
    localparam int AW    = 64;
    localparam int IW    = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [31:0] id;
        logic [63:0] addr;
    } beat_t;

    typedef struct {
        bit          arvalid;
        logic [63:0] addr;
        logic [31:0] id;
        logic [7:0]  len;
        bit          axim_rdy;
        bit          rdy;
        bit          e_arready;
        bit          e_axim_vld;
        logic [63:0] e_axim_addr;
        bit          e_valid;
        bit          e_inprog;
        logic [127:0] e_data;
    } vec_t;

    logic          clk;
    logic          resetn;
    logic          ready;
    logic          valid;
    logic          in_progress;
    logic [DW-1:0] data;
    logic [IW-1:0] AXIS_arid;
    logic [AW-1:0] AXIS_araddr;
    logic [7:0]    AXIS_arlen;
    logic [2:0]    AXIS_arsize;
    logic [1:0]    AXIS_arburst;
    logic [2:0]    AXIS_arprot;
    logic [3:0]    AXIS_arcache;
    logic          AXIS_arvalid;
    logic          AXIS_arready;
    logic [IW-1:0] AXIM_arid;
    logic [AW-1:0] AXIM_araddr;
    logic [7:0]    AXIM_arlen;
    logic [2:0]    AXIM_arsize;
    logic [1:0]    AXIM_arburst;
    logic [2:0]    AXIM_arprot;
    logic [3:0]    AXIM_arcache;
    logic          AXIM_arvalid;
    logic          AXIM_arready;

    axi_ar_to_stream #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ID_WIDTH   (IW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ready        (ready),
        .valid        (valid),
        .in_progress  (in_progress),
        .data         (data),
        .AXIS_arid    (AXIS_arid),
        .AXIS_araddr  (AXIS_araddr),
        .AXIS_arlen   (AXIS_arlen),
        .AXIS_arsize  (AXIS_arsize),
        .AXIS_arburst (AXIS_arburst),
        .AXIS_arprot  (AXIS_arprot),
        .AXIS_arcache (AXIS_arcache),
        .AXIS_arvalid (AXIS_arvalid),
        .AXIS_arready (AXIS_arready),
        .AXIM_arid    (AXIM_arid),
        .AXIM_araddr  (AXIM_araddr),
        .AXIM_arlen   (AXIM_arlen),
        .AXIM_arsize  (AXIM_arsize),
        .AXIM_arburst (AXIM_arburst),
        .AXIM_arprot  (AXIM_arprot),
        .AXIM_arcache (AXIM_arcache),
        .AXIM_arvalid (AXIM_arvalid),
        .AXIM_arready (AXIM_arready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (what the spec says the block holds)
    bit           m_rst_done;
    bit           m_hold_v;
    bit           m_send;
    beat_t        m_hold;
    beat_t        m_fifo[$];
    logic [127:0] m_data;

    // Order scoreboards driven by observed handshakes
    beat_t exp_fwd[$];
    beat_t exp_stream[$];
    int    n_acc, n_fwd, n_strm;
    bit    last_acc;

    function automatic logic [127:0] pack(input beat_t b);
        return {12'h000, b.cache, b.prot, b.burst, b.size, b.len, b.id, b.addr};
    endfunction

    function automatic beat_t mk_beat(input int k);
        beat_t b;
        b.addr  = 64'h0000_0001_0000_2000 + 64'(k) * 64'h40;
        b.id    = 32'h100 + 32'(k);
        b.len   = 8'(k);
        b.size  = 3'(k);
        b.burst = 2'(k);
        b.prot  = 3'(k + 1);
        b.cache = 4'(k + 3);
        return b;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        b.addr  = {$urandom, $urandom};
        b.id    = $urandom;
        b.len   = 8'($urandom);
        b.size  = 3'($urandom);
        b.burst = 2'($urandom);
        b.prot  = 3'($urandom);
        b.cache = 4'($urandom);
        return b;
    endfunction

    task automatic set_beat(input beat_t b);
        AXIS_araddr  = b.addr;
        AXIS_arid    = b.id;
        AXIS_arlen   = b.len;
        AXIS_arsize  = b.size;
        AXIS_arburst = b.burst;
        AXIS_arprot  = b.prot;
        AXIS_arcache = b.cache;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name, input string msg);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s at %0t", name, msg, $time);
    endtask

    task automatic model_reset();
        m_rst_done = 1'b0;
        m_hold_v   = 1'b0;
        m_send     = 1'b0;
        m_hold     = '0;
        m_data     = '0;
        m_fifo.delete();
        exp_fwd.delete();
        exp_stream.delete();
    endtask

    // Called at posedge+1 with inputs set; compares, advances model, returns at next posedge+1.
    task automatic cycle();
        beat_t cur, dh;
        bit    p_ardy, p_valid, acc, fwd, m_acc, m_pop;
        #2;
        cur.addr = AXIS_araddr;  cur.id = AXIS_arid;     cur.len = AXIS_arlen;
        cur.size = AXIS_arsize;  cur.burst = AXIS_arburst;
        cur.prot = AXIS_arprot;  cur.cache = AXIS_arcache;
        dh.addr  = AXIM_araddr;  dh.id = AXIM_arid;      dh.len = AXIM_arlen;
        dh.size  = AXIM_arsize;  dh.burst = AXIM_arburst;
        dh.prot  = AXIM_arprot;  dh.cache = AXIM_arcache;
        p_ardy  = m_rst_done && (!m_hold_v || AXIM_arready) && (m_fifo.size() < DEPTH);
        p_valid = !m_send && (m_fifo.size() != 0);
        chk1("AXIS_arready", AXIS_arready, p_ardy);
        chk1("AXIM_arvalid", AXIM_arvalid, m_hold_v);
        chkw("AXIM_payload", pack(dh), pack(m_hold));
        chk1("valid", valid, p_valid);
        chk1("in_progress", in_progress, m_send);
        chkw("data", data, m_data);
        acc = AXIS_arvalid && AXIS_arready;
        fwd = AXIM_arvalid && AXIM_arready;
        last_acc = acc;
        if (!resetn) begin
            model_reset();
        end else begin
            if (fwd) begin
                n_fwd++;
                if (exp_fwd.size() == 0) fail_msg("fwd_extra", "forwarded AR with none outstanding");
                else chkw("fwd_order", pack(dh), pack(exp_fwd.pop_front()));
            end
            if (in_progress) begin
                n_strm++;
                if (exp_stream.size() == 0) fail_msg("stream_extra", "packet with no accepted AR");
                else chkw("stream_order", data, pack(exp_stream.pop_front()));
            end
            if (acc) begin
                n_acc++;
                exp_fwd.push_back(cur);
                exp_stream.push_back(cur);
            end
            m_acc = AXIS_arvalid && p_ardy;
            m_pop = p_valid && ready;
            if (m_pop) begin
                m_data = pack(m_fifo[0]);
                void'(m_fifo.pop_front());
            end
            m_send = m_pop;
            if (m_acc) begin
                m_fifo.push_back(cur);
                m_hold   = cur;
                m_hold_v = 1'b1;
            end else if (AXIM_arready) begin
                m_hold_v = 1'b0;
            end
            m_rst_done = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        AXIS_arvalid = 1'b0;
        AXIM_arready = 1'b0;
        ready        = 1'b0;
        set_beat('0);
        resetn = 1'b0;
        #1;
        model_reset();
        cycle();
        cycle();
        resetn = 1'b1;
        cycle();
        n_acc = 0; n_fwd = 0; n_strm = 0;
    endtask

    vec_t vt[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int    k;
        int    a0;
        beat_t b;
        resetn = 1'b0;
        AXIS_arvalid = 1'b0;
        AXIM_arready = 1'b0;
        ready = 1'b0;
        set_beat('0);
        model_reset();

        // Reset state
        #3;
        chk1("rst_valid", valid, 1'b0);
        chk1("rst_in_progress", in_progress, 1'b0);
        chkw("rst_data", data, '0);
        chk1("rst_AXIM_arvalid", AXIM_arvalid, 1'b0);
        chk1("rst_AXIS_arready", AXIS_arready, 1'b0);
        chkw("rst_AXIM_araddr", {64'h0, AXIM_araddr}, '0);
        @(posedge clk);
        #1;

        // Single AR vector table
        vt[0] = '{1, 64'h1000, 32'h5, 8'd7, 1, 1, 1, 0, 64'h0,    0, 0, 128'h0};
        vt[1] = '{0, 64'h0,    32'h0, 8'd0, 1, 1, 1, 1, 64'h1000, 1, 0, 128'h0};
        vt[2] = '{0, 64'h0,    32'h0, 8'd0, 1, 1, 1, 0, 64'h1000, 0, 1,
                  128'h00000007_00000005_00000000_00001000};
        vt[3] = '{0, 64'h0,    32'h0, 8'd0, 1, 1, 1, 0, 64'h1000, 0, 0,
                  128'h00000007_00000005_00000000_00001000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            b = '0;
            b.addr = vt[i].addr; b.id = vt[i].id; b.len = vt[i].len;
            set_beat(b);
            AXIS_arvalid = vt[i].arvalid;
            AXIM_arready = vt[i].axim_rdy;
            ready        = vt[i].rdy;
            #1;
            chk1($sformatf("tbl%0d_arready", i), AXIS_arready, vt[i].e_arready);
            chk1($sformatf("tbl%0d_axim_vld", i), AXIM_arvalid, vt[i].e_axim_vld);
            chkw($sformatf("tbl%0d_axim_addr", i), {64'h0, AXIM_araddr}, {64'h0, vt[i].e_axim_addr});
            chk1($sformatf("tbl%0d_valid", i), valid, vt[i].e_valid);
            chk1($sformatf("tbl%0d_inprog", i), in_progress, vt[i].e_inprog);
            chkw($sformatf("tbl%0d_data", i), data, vt[i].e_data);
            cycle();
        end

        // Back-to-back ARs with the stream never granted: FIFO fills at four
        do_reset();
        AXIM_arready = 1'b1; ready = 1'b0; AXIS_arvalid = 1'b1;
        k = 0; set_beat(mk_beat(k));
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_acc) k++;
            set_beat(mk_beat(k));
        end
        chk_int("b2b_accepted", n_acc, 4);
        AXIS_arvalid = 1'b0;
        #1;
        chk1("b2b_arready_low", AXIS_arready, 1'b0);
        chk1("b2b_valid_high", valid, 1'b1);
        cycle();

        // Downstream stall for five cycles, then release
        do_reset();
        AXIM_arready = 1'b0; ready = 1'b1; AXIS_arvalid = 1'b1;
        k = 0; set_beat(mk_beat(k));
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (last_acc) k++;
            set_beat(mk_beat(k));
        end
        chk_int("stall_accepted", n_acc, 1);
        chkw("stall_stable", {64'h0, AXIM_araddr}, {64'h0, mk_beat(0).addr});
        AXIM_arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (last_acc) k++;
            set_beat(mk_beat(k));
        end
        AXIS_arvalid = 1'b0;
        for (int i = 0; i < 12; i++) cycle();
        chk_int("stall_fwd_all", n_fwd, n_acc);

        // Full FIFO with continuous stream grant: one push per packet slot
        do_reset();
        AXIM_arready = 1'b1; ready = 1'b0; AXIS_arvalid = 1'b1;
        k = 0; set_beat(mk_beat(k));
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (last_acc) k++;
            set_beat(mk_beat(k));
        end
        chk_int("full_fill", n_acc, 4);
        a0 = n_acc;
        ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (last_acc) k++;
            set_beat(mk_beat(k));
        end
        chk_int("full_alternate", n_acc - a0, 10);
        AXIS_arvalid = 1'b0;
        for (int i = 0; i < 12; i++) cycle();
        chk_int("full_no_loss", n_strm, n_acc);

        // Randomized traffic
        do_reset();
        AXIS_arvalid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!(AXIS_arvalid && !last_acc)) begin
                AXIS_arvalid = ($urandom_range(0, 9) < 7);
                set_beat(rnd_beat());
            end
            AXIM_arready = ($urandom_range(0, 3) != 0);
            ready        = ($urandom_range(0, 2) != 0);
            cycle();
        end
        AXIS_arvalid = 1'b0; AXIM_arready = 1'b1; ready = 1'b1;
        for (int i = 0; i < 14; i++) cycle();
        chk_int("rand_stream_count", n_strm, n_acc);
        chk_int("rand_fwd_count", n_fwd, n_acc);

        // Asynchronous reset while a packet is being sent
        do_reset();
        AXIM_arready = 1'b0; ready = 1'b0; AXIS_arvalid = 1'b1;
        k = 0; set_beat(mk_beat(k));
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (last_acc) k++;
            set_beat(mk_beat(k));
        end
        ready = 1'b1;
        cycle();
        #1;
        chk1("pre_rst_in_progress", in_progress, 1'b1);
        chk1("pre_rst_AXIM_arvalid", AXIM_arvalid, 1'b1);
        resetn = 1'b0;
        #1;
        chk1("async_rst_in_progress", in_progress, 1'b0);
        chk1("async_rst_valid", valid, 1'b0);
        chk1("async_rst_AXIM_arvalid", AXIM_arvalid, 1'b0);
        chk1("async_rst_AXIS_arready", AXIS_arready, 1'b0);
        chkw("async_rst_data", data, '0);
        chkw("async_rst_AXIM_araddr", {64'h0, AXIM_araddr}, '0);
        model_reset();
        AXIS_arvalid = 1'b0; ready = 1'b1; AXIM_arready = 1'b1;
        cycle();
        cycle();
        resetn = 1'b1;
        n_strm = 0;
        for (int i = 0; i < 8; i++) cycle();
        chk_int("rst_no_stale_packet", n_strm, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
